// File: rtl/bitwise_pkg.sv
// Shared op encoding for the bitwise/logic execution unit.
package bitwise_pkg;

    localparam int BL_OP_W = 4;

    // Codes 13-15 are reserved and evaluate to zero.
    typedef enum logic [BL_OP_W-1:0] {
        BL_AND   = 4'd0,
        BL_OR    = 4'd1,
        BL_XOR   = 4'd2,
        BL_NOR   = 4'd3,
        BL_NAND  = 4'd4,
        BL_XNOR  = 4'd5,
        BL_ANDN  = 4'd6,
        BL_ORN   = 4'd7,
        BL_RAND  = 4'd8,
        BL_ROR   = 4'd9,
        BL_RXOR  = 4'd10,
        BL_PASSA = 4'd11,
        BL_NOTA  = 4'd12
    } bl_op_e;

endpackage

// File: rtl/elastic_pipe_stage.sv
// One valid/ready register slice; ready is chained combinationally from downstream.
module elastic_pipe_stage #(
    parameter int DW = 33
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    // Loads when empty or when the held beat is leaving this cycle.
    assign ready_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ready_o) begin
            valid_d = valid_i;
        end
        // Data only moves with a real beat so the output holds its last value when idle.
        if (valid_i && ready_o) begin
            data_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/bitwise_logic_unit.sv
// Pipelined bitwise/logic unit: op evaluated at acceptance, result + zero flag
// carried through STAGES elastic slices.
module bitwise_logic_unit
    import bitwise_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [BL_OP_W-1:0] i_op,
    input  logic [WIDTH-1:0]   i_1,
    input  logic [WIDTH-1:0]   i_2,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o,
    output logic               o_zero
);

    logic [WIDTH-1:0] op_a, op_b, res_d;
    logic             zero_d;

    always_comb begin
        op_a  = enable ? i_1 : '0;
        op_b  = enable ? i_2 : '0;
        res_d = '0;
        case (bl_op_e'(i_op))
            BL_AND:   res_d = op_a & op_b;
            BL_OR:    res_d = op_a | op_b;
            BL_XOR:   res_d = op_a ^ op_b;
            BL_NOR:   res_d = ~(op_a | op_b);
            BL_NAND:  res_d = ~(op_a & op_b);
            BL_XNOR:  res_d = ~(op_a ^ op_b);
            BL_ANDN:  res_d = op_a & ~op_b;
            BL_ORN:   res_d = op_a | ~op_b;
            BL_RAND:  res_d[0] = &op_a;
            BL_ROR:   res_d[0] = |op_a;
            BL_RXOR:  res_d[0] = ^op_a;
            BL_PASSA: res_d = op_a;
            BL_NOTA:  res_d = ~op_a;
            default:  res_d = '0;
        endcase
        zero_d = (res_d == '0);
    end

    // Each slice gets its own scalar handshake nets so the backward ready chain
    // is a plain sequence of gates rather than a self-referencing vector.
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic             v_in, r_in, v_out, r_dn;
        logic [WIDTH:0]   d_in, d_out;

        if (g == 0) begin : g_head
            assign v_in = i_valid;
            assign d_in = {zero_d, res_d};
        end else begin : g_link
            assign v_in = g_stage[g-1].v_out;
            assign d_in = g_stage[g-1].d_out;
        end

        if (g == STAGES - 1) begin : g_tail
            assign r_dn = i_ready;
        end else begin : g_mid
            assign r_dn = g_stage[g+1].r_in;
        end

        elastic_pipe_stage #(
            .DW(WIDTH + 1)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .valid_i(v_in),
            .ready_o(r_in),
            .data_i (d_in),
            .valid_o(v_out),
            .ready_i(r_dn),
            .data_o (d_out)
        );
    end

    assign o_ready = g_stage[0].r_in;
    assign o_valid = g_stage[STAGES-1].v_out;
    assign o       = g_stage[STAGES-1].d_out[WIDTH-1:0];
    assign o_zero  = g_stage[STAGES-1].d_out[WIDTH];

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench: directed cases plus randomized ops/operands/stalls
// scored against a behavioural model through an in-order expectation queue.
module tb_bitwise_logic_unit;
    import bitwise_pkg::*;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable, i_valid, i_ready;
    logic [3:0]       i_op;
    logic [WIDTH-1:0] i_1, i_2;
    logic             o_ready, o_valid, o_zero;
    logic [WIDTH-1:0] o;

    bitwise_logic_unit #(.WIDTH(WIDTH), .STAGES(STAGES)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_op   (i_op),
        .i_1    (i_1),
        .i_2    (i_2),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o      (o),
        .o_zero (o_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [32:0] ev;
        int          c;
    } sb_t;

    sb_t        sb[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         cyc   = 0;
    int         n_acc = 0;
    bit         lat_mode = 1'b1;
    logic       s_ordy, s_ovalid;
    logic [31:0] s_o;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference: plain arithmetic on the op definitions; returns {zero, result}.
    function automatic logic [32:0] model(input int op, input logic [31:0] a_in,
                                          input logic [31:0] b_in, input bit en);
        logic [31:0] a, b, r;
        a = en ? a_in : 32'd0;
        b = en ? b_in : 32'd0;
        case (op)
            0:  r = a & b;
            1:  r = a | b;
            2:  r = a ^ b;
            3:  r = ~(a | b);
            4:  r = ~(a & b);
            5:  r = ~(a ^ b);
            6:  r = a & ~b;
            7:  r = a | ~b;
            8:  r = (a == 32'hFFFF_FFFF) ? 32'd1 : 32'd0;
            9:  r = (a != 32'd0) ? 32'd1 : 32'd0;
            10: r = 32'($countones(a) % 2);
            11: r = a;
            12: r = ~a;
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    // One cycle: drive at negedge, score handshakes once settled, then cross the edge.
    task automatic step(input bit v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit en, input bit rdy,
                        input logic [32:0] ev);
        sb_t e;
        @(negedge clk);
        i_valid = v; i_op = op; i_1 = a; i_2 = b; enable = en; i_ready = rdy;
        #1;
        s_ordy = o_ready; s_ovalid = o_valid; s_o = o;
        if (o_valid && i_ready) begin
            if (sb.size() == 0) begin
                chk("stale_beat", 64'(o_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("o", 64'(o), 64'(e.ev[31:0]));
                chk("o_zero", 64'(o_zero), 64'(e.ev[32]));
                if (lat_mode) chk("latency", 64'(cyc - e.c), 64'(STAGES));
            end
        end
        if (i_valid && o_ready) begin
            sb.push_back(sb_t'{ev: ev, c: cyc});
            n_acc++;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, rdy, 33'd0);
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) idle(1'b1);
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_op = 4'd0; i_1 = '0; i_2 = '0;
        #12;
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o", 64'(o), 64'd0);
        chk("rst_o_zero", 64'(o_zero), 64'd0);
        chk("rst_o_ready", 64'(o_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single OR beat, latency STAGES.
        step(1'b1, BL_OR, 32'hF0F0_0000, 32'h0000_0F0F, 1'b1, 1'b1, 33'h0_F0F0_0F0F);
        drain(10);

        // Back-to-back ops on consecutive cycles.
        step(1'b1, BL_AND,  32'hFFFF_0001, 32'h0000_0001, 1'b1, 1'b1, 33'h0_0000_0001);
        step(1'b1, BL_XOR,  32'hFFFF_0001, 32'h0000_0001, 1'b1, 1'b1, 33'h0_FFFF_0000);
        step(1'b1, BL_NOR,  32'hFFFF_0001, 32'h0000_0001, 1'b1, 1'b1, 33'h0_0000_FFFE);
        step(1'b1, BL_ANDN, 32'hFFFF_0001, 32'h0000_0001, 1'b1, 1'b1, 33'h0_FFFF_0000);
        step(1'b1, BL_RXOR, 32'hFFFF_0001, 32'h0000_0001, 1'b1, 1'b1, 33'h0_0000_0001);
        drain(10);

        // Gated operands and a reserved op.
        step(1'b1, BL_NOR, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 33'h0_FFFF_FFFF);
        step(1'b1, BL_OR,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 33'h1_0000_0000);
        step(1'b1, 4'd14,  32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1, 33'h1_0000_0000);
        drain(10);

        // Downstream stall for 5 cycles with input always offered.
        lat_mode = 1'b0;
        step(1'b1, BL_PASSA, 32'h1, 32'h0, 1'b1, 1'b0, 33'h0_0000_0001);
        step(1'b1, BL_PASSA, 32'h2, 32'h0, 1'b1, 1'b0, 33'h0_0000_0002);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, BL_PASSA, 32'h3, 32'h0, 1'b1, 1'b0, 33'h0_0000_0003);
            chk("stall_o_ready", 64'(s_ordy), 64'd0);
            chk("stall_o_valid", 64'(s_ovalid), 64'd1);
            chk("stall_o_hold", 64'(s_o), 64'd1);
        end
        step(1'b1, BL_PASSA, 32'h3, 32'h0, 1'b1, 1'b1, 33'h0_0000_0003);
        chk("release_o_ready", 64'(s_ordy), 64'd1);
        drain(10);
        lat_mode = 1'b1;

        // Async reset with two beats in flight.
        step(1'b1, BL_PASSA, 32'hAAAA_0001, 32'h0, 1'b1, 1'b1, 33'h0_AAAA_0001);
        step(1'b1, BL_PASSA, 32'hAAAA_0002, 32'h0, 1'b1, 1'b1, 33'h0_AAAA_0002);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_o_valid", 64'(o_valid), 64'd0);
        chk("arst_o", 64'(o), 64'd0);
        chk("arst_o_zero", 64'(o_zero), 64'd0);
        chk("arst_o_ready", 64'(o_ready), 64'd1);
        sb.delete();
        @(negedge clk);
        i_valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) idle(1'b1);
        chk("post_rst_o_valid", 64'(s_ovalid), 64'd0);

        // Randomized ops, operands, enable, valid and stalls.
        lat_mode = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 60000 && n_acc < 10000; k++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            bit          en, v, rdy;
            op  = 4'($urandom_range(0, 15));
            a   = $urandom();
            b   = $urandom();
            if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'hFFFF_FFFF;
            en  = ($urandom_range(0, 9) != 0);
            v   = ($urandom_range(0, 4) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(v, op, a, b, en, rdy, model(int'(op), a, b, en));
        end
        chk("rand_beats", 64'(n_acc), 64'd10000);
        drain(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
